// File: rtl/osc_ker_req_ctrl.sv
// Shared-oscillator request controller: wakes the oscillator on any kernel-clock
// request, grants once ready, and holds it on for a hysteresis window before stopping.
module osc_ker_req_ctrl #(
    parameter int REQ_NUM      = 4,
    parameter int WAKE_TIMEOUT = 255,
    parameter int HOLD_CYCLES  = 16
) (
    input  logic               i_clk,
    input  logic               sys_rst,
    input  logic [REQ_NUM-1:0] ker_clk_req,
    input  logic               force_on,
    input  logic               osc_rdy,
    input  logic               err_clr,
    output logic               osc_en,
    output logic [REQ_NUM-1:0] ker_clk_gnt,
    output logic               timeout_err,
    output logic               rdy_lost_err,
    output logic [2:0]         osc_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAKE = 3'd1,
        RUN  = 3'd2,
        HOLD = 3'd3,
        STOP = 3'd4
    } state_e;

    localparam logic [7:0] WAKE_LAST = 8'(WAKE_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 rdy_meta_q, rdy_s_q;
    logic                 osc_en_q, osc_en_d;
    logic [REQ_NUM-1:0]   gnt_q, gnt_d;
    logic                 tmo_q, tmo_d;
    logic                 lost_q, lost_d;
    logic                 any_req;
    logic                 cnt_clr;
    logic                 tmo_set;
    logic                 lost_set;

    assign any_req = (|ker_clk_req) | force_on;

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        tmo_set  = 1'b0;
        lost_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = WAKE;
                    cnt_clr = 1'b1;
                end
            end
            WAKE: begin
                if (rdy_s_q) begin
                    state_d = RUN;
                end else if (!any_req) begin
                    state_d = STOP;
                end else if (cnt_q >= WAKE_LAST) begin
                    state_d = STOP;
                    tmo_set = 1'b1;
                end
            end
            RUN: begin
                if (!rdy_s_q) begin
                    state_d  = WAKE;
                    cnt_clr  = 1'b1;
                    lost_set = 1'b1;
                end else if (!any_req) begin
                    state_d = HOLD;
                    cnt_clr = 1'b1;
                end
            end
            HOLD: begin
                if (any_req && rdy_s_q) begin
                    state_d = RUN;
                end else if (any_req) begin
                    state_d = WAKE;
                    cnt_clr = 1'b1;
                end else if (cnt_q >= HOLD_LAST) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Late requests wait for the oscillator to report not-ready first.
                if (!rdy_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = 8'd0;
        end else if ((state_q == WAKE || state_q == HOLD) && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign osc_en_d = (state_d == WAKE) || (state_d == RUN) || (state_d == HOLD);
    assign gnt_d    = (state_q == RUN && rdy_s_q) ? ker_clk_req : '0;
    assign tmo_d    = tmo_set | (tmo_q & ~err_clr);
    assign lost_d   = lost_set | (lost_q & ~err_clr);

    always_ff @(posedge i_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            osc_en_q   <= 1'b0;
            gnt_q      <= '0;
            tmo_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            rdy_meta_q <= osc_rdy;
            rdy_s_q    <= rdy_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            osc_en_q   <= osc_en_d;
            gnt_q      <= gnt_d;
            tmo_q      <= tmo_d;
            lost_q     <= lost_d;
        end
    end

    assign osc_en       = osc_en_q;
    assign ker_clk_gnt  = gnt_q;
    assign timeout_err  = tmo_q;
    assign rdy_lost_err = lost_q;
    assign osc_state    = state_q;

endmodule

// File: tb/tb_osc_ker_req_ctrl.sv
// Bench for osc_ker_req_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_osc_ker_req_ctrl;
    localparam int N  = 4;
    localparam int WT = 8;
    localparam int HC = 4;

    logic         i_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic [N-1:0] ker_clk_req = '0;
    logic         force_on = 1'b0;
    logic         osc_rdy = 1'b0;
    logic         err_clr = 1'b0;
    logic         osc_en;
    logic [N-1:0] ker_clk_gnt;
    logic         timeout_err;
    logic         rdy_lost_err;
    logic [2:0]   osc_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cy      = 0;

    osc_ker_req_ctrl #(.REQ_NUM(N), .WAKE_TIMEOUT(WT), .HOLD_CYCLES(HC)) dut (
        .i_clk(i_clk), .sys_rst(sys_rst), .ker_clk_req(ker_clk_req), .force_on(force_on),
        .osc_rdy(osc_rdy), .err_clr(err_clr), .osc_en(osc_en), .ker_clk_gnt(ker_clk_gnt),
        .timeout_err(timeout_err), .rdy_lost_err(rdy_lost_err), .osc_state(osc_state)
    );

    always #5 i_clk = ~i_clk;

    // Model: state as spec code, age = cycles spent in the current state.
    typedef struct {
        int         st;
        int         age;
        bit         en;
        bit [N-1:0] gnt;
        bit         tmo;
        bit         lost;
    } mdl_t;

    mdl_t     m;
    bit [1:0] rdy_hist;

    function automatic mdl_t mdl_rst();
        mdl_t r;
        r.st = 0; r.age = 0; r.en = 1'b0; r.gnt = '0; r.tmo = 1'b0; r.lost = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mdl_next(mdl_t c, bit rs, bit [N-1:0] req, bit fo, bit clr);
        mdl_t n = c;
        bit any = (req != 0) || fo;
        bit set_t = 1'b0;
        bit set_l = 1'b0;
        case (c.st)
            0: if (any) n.st = 1;
            1: if (rs) n.st = 2;
               else if (!any) n.st = 4;
               else if (c.age >= WT - 1) begin n.st = 4; set_t = 1'b1; end
            2: if (!rs) begin n.st = 1; set_l = 1'b1; end
               else if (!any) n.st = 3;
            3: if (any && rs) n.st = 2;
               else if (any) n.st = 1;
               else if (c.age >= HC - 1) n.st = 4;
            default: if (!rs) n.st = 0;
        endcase
        n.gnt  = (c.st == 2 && rs) ? req : '0;
        n.tmo  = set_t || (c.tmo && !clr);
        n.lost = set_l || (c.lost && !clr);
        n.age  = (n.st != c.st) ? 0 : c.age + 1;
        n.en   = (n.st == 1) || (n.st == 2) || (n.st == 3);
        return n;
    endfunction

    // rdy_hist[1] is osc_rdy as sampled two edges ago, i.e. the synchronized view.
    always @(posedge i_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m        <= mdl_rst();
            rdy_hist <= 2'b00;
        end else begin
            m        <= mdl_next(m, rdy_hist[1], ker_clk_req, force_on, err_clr);
            rdy_hist <= {rdy_hist[0], osc_rdy};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        chk("model_en",    32'(osc_en),       32'(m.en));
        chk("model_gnt",   32'(ker_clk_gnt),  32'(m.gnt));
        chk("model_tmo",   32'(timeout_err),  32'(m.tmo));
        chk("model_lost",  32'(rdy_lost_err), 32'(m.lost));
        chk("model_state", 32'(osc_state),    32'(m.st));
    end

    task automatic goto(input int c);
        while (cy < c) begin
            @(posedge i_clk);
            #2;
            cy++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},    32'(osc_en),       0);
        chk({tag, "_gnt"},   32'(ker_clk_gnt),  0);
        chk({tag, "_state"}, 32'(osc_state),    0);
        chk({tag, "_tmo"},   32'(timeout_err),  0);
        chk({tag, "_lost"},  32'(rdy_lost_err), 0);
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #2;
        chk_all_zero("reset");

        // Basic bring-up, ready loss, hysteresis, force_on, reset in HOLD
        sys_rst = 1'b0; cy = 0;
        ker_clk_req = 4'b0010;
        goto(1);  chk("basic_en_c1", 32'(osc_en), 1);
        goto(3);  osc_rdy = 1'b1;
        goto(5);  chk("basic_wake_c5", 32'(osc_state), 1);
        goto(6);  chk("basic_run_c6", 32'(osc_state), 2);
                  chk("basic_nognt_c6", 32'(ker_clk_gnt), 0);
        goto(7);  chk("basic_gnt_c7", 32'(ker_clk_gnt), 32'h2);
                  ker_clk_req = 4'b1001;
        goto(8);  chk("gnt_1001", 32'(ker_clk_gnt), 32'h9);
        goto(9);  osc_rdy = 1'b0;
        goto(11); chk("still_run", 32'(osc_state), 2);
        goto(12); chk("lost_state", 32'(osc_state), 1);
                  chk("lost_flag", 32'(rdy_lost_err), 1);
                  chk("lost_gnt", 32'(ker_clk_gnt), 0);
                  osc_rdy = 1'b1;
        goto(15); chk("relock_run", 32'(osc_state), 2);
        goto(16); chk("relock_gnt", 32'(ker_clk_gnt), 32'h9);
                  ker_clk_req = '0;
        goto(17); chk("hold_enter", 32'(osc_state), 3);
        goto(18); ker_clk_req = 4'b0100;
        goto(19); chk("hold_rerun", 32'(osc_state), 2);
                  chk("hold_en_kept", 32'(osc_en), 1);
                  ker_clk_req = '0;
        goto(20); osc_rdy = 1'b0;
        goto(23); chk("hold_last", 32'(osc_state), 3);
        goto(24); chk("stop_state", 32'(osc_state), 4);
                  chk("stop_en", 32'(osc_en), 0);
        goto(25); chk("idle_after_stop", 32'(osc_state), 0);
                  force_on = 1'b1; osc_rdy = 1'b1;
        goto(28); chk("force_run", 32'(osc_state), 2);
        goto(29); chk("force_nognt", 32'(ker_clk_gnt), 0);
                  chk("lost_sticky", 32'(rdy_lost_err), 1);
                  force_on = 1'b0;
        goto(30); chk("hold_before_rst", 32'(osc_state), 3);
        sys_rst = 1'b1;
        #1;
        chk_all_zero("rst_hold");

        // Timeout, request served after STOP, err_clr and set-wins
        @(posedge i_clk); #2;
        sys_rst = 1'b0; cy = 0;
        ker_clk_req = 4'b0001; osc_rdy = 1'b0;
        goto(8);  chk("tmo_pre", 32'(timeout_err), 0);
                  chk("tmo_wake_c8", 32'(osc_state), 1);
        goto(9);  chk("tmo_set", 32'(timeout_err), 1);
                  chk("tmo_stop", 32'(osc_state), 4);
                  chk("tmo_en", 32'(osc_en), 0);
        goto(10); chk("tmo_idle", 32'(osc_state), 0);
        goto(11); chk("tmo_rewake", 32'(osc_state), 1);
                  err_clr = 1'b1;
        goto(12); err_clr = 1'b0;
                  chk("tmo_cleared", 32'(timeout_err), 0);
        goto(18); err_clr = 1'b1;
        goto(19); err_clr = 1'b0;
                  chk("tmo_set_wins", 32'(timeout_err), 1);
                  chk("tmo_stop2", 32'(osc_state), 4);

        // Randomized traffic; the model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge i_clk); #2;
            err_clr = ($urandom_range(15) == 0);
            if ($urandom_range(7) == 0)
                ker_clk_req = ($urandom_range(2) == 0) ? '0 : 4'($urandom);
            if ($urandom_range(31) == 0) force_on = ~force_on;
            if ($urandom_range(4) == 0) osc_rdy = osc_en;
            else if ($urandom_range(39) == 0) osc_rdy = ~osc_rdy;
            if (sys_rst) begin
                sys_rst = 1'b0;
            end else if ($urandom_range(299) == 0) begin
                sys_rst = 1'b1;
                #1;
                chk_all_zero("rst_rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
